// File: rtl/up_memory_pkg.sv
// Shared definitions for up_memory_dp: boot image contents and the init/run state type.
package up_memory_pkg;

    localparam int unsigned BOOT_LEN = 11;

    localparam logic [7:0] BOOT_IMAGE [BOOT_LEN] = '{
        8'h00, 8'h00, 8'h6C, 8'h00, 8'h99, 8'h99,
        8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'h80
    };

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // Words beyond the image sweep to zero.
    function automatic logic [7:0] boot_word(input int unsigned idx);
        logic [3:0] i;
        i = idx[3:0];
        return (idx < BOOT_LEN) ? BOOT_IMAGE[i] : 8'h00;
    endfunction

endpackage

// File: rtl/up_memory_init.sv
// Post-reset sweep sequencer: walks every word once, supplying boot-image data then zeroes.
module up_memory_init
    import up_memory_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              nRst,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              re
);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= INIT;
            cnt   <= '0;
            re    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    // The edge writing the last word is the one that releases the core.
                    if (cnt == '1) begin
                        state <= RUN;
                        re    <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign init_addr = cnt;

    always_comb begin
        init_data      = '0;
        init_data[7:0] = boot_word(32'(cnt));
    end

endmodule

// File: rtl/up_memory_dp.sv
// Dual-port program/data memory: combinational fetch port, read/write data port, swept init.
// Define UP_MEMORY_WPROT_EN to make words 0..PROT_TOP-1 read-only once running.
module up_memory_dp
    import up_memory_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          ADDR_W   = 8,
    parameter int unsigned PROT_TOP = 16
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] out_a,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              we,
    output logic [DATA_W-1:0] out,
    output logic              re,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef UP_MEMORY_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    logic              wr_prot;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    up_memory_init #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_init (
        .clk       (clk),
        .nRst      (nRst),
        .init_addr (init_addr),
        .init_data (init_data),
        .re        (re)
    );

    assign wr_prot = WPROT_EN && (32'(address) < PROT_TOP);

    // The sweep owns the write port until re rises; the data port is locked out meanwhile.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = in;
        if (!re) begin
            mem_we    = 1'b1;
            mem_addr  = init_addr;
            mem_wdata = init_data;
        end else if (we && !wr_prot) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            err <= 1'b0;
        end else begin
            err <= we && (!re || wr_prot);
        end
    end

    assign out_a = re ? mem[addr_a]  : '0;
    assign out   = re ? mem[address] : '0;

endmodule

// File: tb/tb_up_memory_dp.sv
// Self-checking bench for up_memory_dp: 8-bit and 16-bit instances, boot sweep, R/W table, resets.
module tb_up_memory_dp;

`ifdef UP_MEMORY_WPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRst = 1'b0;

    logic [7:0]  addr_a8, address8, in8, out_a8, out8;
    logic        we8, re8, err8;
    logic [7:0]  addr_a16, address16;
    logic [15:0] in16, out_a16, out16;
    logic        we16, re16, err16;

    always #5 clk = ~clk;

    up_memory_dp dut8 (
        .clk     (clk),
        .nRst    (nRst),
        .addr_a  (addr_a8),
        .out_a   (out_a8),
        .address (address8),
        .in      (in8),
        .we      (we8),
        .out     (out8),
        .re      (re8),
        .err     (err8)
    );

    up_memory_dp #(.DATA_W(16)) dut16 (
        .clk     (clk),
        .nRst    (nRst),
        .addr_a  (addr_a16),
        .out_a   (out_a16),
        .address (address16),
        .in      (in16),
        .we      (we16),
        .out     (out16),
        .re      (re16),
        .err     (err16)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       we;
        logic [7:0] addr_a;
        logic [7:0] address;
        logic [7:0] wdata;
        logic [7:0] exp_a;
        logic [7:0] exp_d;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];
    logic err_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs from a negedge just after reset release until re8 rises (bounded).
    task automatic sweep(input int we_edge, output int re_edge, output int err_hits,
                         output int err_first, output int early_rd, output logic re16_at_end);
        re_edge = 0; err_hits = 0; err_first = 0; early_rd = 0;
        for (int k = 1; k <= 300 && re_edge == 0; k++) begin
            we8      = (k == we_edge);
            address8 = 8'h40;
            in8      = 8'h77;
            addr_a8  = 8'h02;
            addr_a16 = 8'h04;
            @(posedge clk);
            #1;
            if (err8) begin
                err_hits++;
                if (err_first == 0) err_first = k;
            end
            if (re8) re_edge = k;
            else if (out_a8 !== 8'h00 || out8 !== 8'h00 || out_a16 !== 16'h0000) early_rd++;
        end
        re16_at_end = re16;
        we8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic read8(input string name, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        addr_a8  = a;
        address8 = a;
        #1;
        check({name, "_a"}, 32'(out_a8), 32'(exp));
        check({name, "_d"}, 32'(out8), 32'(exp));
    endtask

    int   re_edge, err_hits, err_first, early_rd;
    logic re16_end;

    initial begin
        we8 = 1'b0; addr_a8 = '0; address8 = '0; in8 = '0;
        we16 = 1'b0; addr_a16 = '0; address16 = '0; in16 = '0;
        repeat (2) @(negedge clk);
        addr_a8 = 8'h02; address8 = 8'h02; addr_a16 = 8'h04; address16 = 8'h04;
        #1;
        check("rst_re", 32'(re8), 0);
        check("rst_err", 32'(err8), 0);
        check("rst_out_a", 32'(out_a8), 0);
        check("rst_out", 32'(out8), 0);
        check("rst_out16", 32'(out16), 0);

        nRst = 1'b1;
        sweep(10, re_edge, err_hits, err_first, early_rd, re16_end);
        check("re_rise_edge", 32'(re_edge), 256);
        check("re16_rise", 32'(re16_end), 1);
        check("init_we_err_edge", 32'(err_first), 10);
        check("init_we_err_len", 32'(err_hits), 1);
        check("init_reads_zero", 32'(early_rd), 0);

        //            we    addr_a  address wdata   exp_a   exp_d   exp_err
        vecs.push_back('{1'b0, 8'h02, 8'h0A, 8'h00, 8'h6C, 8'h80, 1'b0});
        vecs.push_back('{1'b0, 8'hC8, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'h04, 8'h07, 8'h00, 8'h99, 8'hAA, 1'b0});
        vecs.push_back('{1'b0, 8'h08, 8'h0B, 8'h00, 8'hBB, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 8'h40, 8'h40, 8'h5A, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'h40, 8'h40, 8'h00, 8'h5A, 8'h5A, 1'b0});
        vecs.push_back('{1'b1, 8'h02, 8'h02, 8'hFF, 8'h6C, 8'h6C, PROT});
        vecs.push_back('{1'b0, 8'h02, 8'h02, 8'h00, PROT ? 8'h6C : 8'hFF, PROT ? 8'h6C : 8'hFF, 1'b0});
        vecs.push_back('{1'b1, 8'h10, 8'h10, 8'h33, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'h10, 8'h10, 8'h00, 8'h33, 8'h33, 1'b0});
        vecs.push_back('{1'b1, 8'h0F, 8'h0F, 8'h44, 8'h00, 8'h00, PROT});
        vecs.push_back('{1'b0, 8'h0F, 8'h0F, 8'h00, PROT ? 8'h00 : 8'h44, PROT ? 8'h00 : 8'h44, 1'b0});
        vecs.push_back('{1'b1, 8'hFF, 8'hFF, 8'hC3, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'hFF, 8'h00, 8'h00, 8'hC3, 8'h00, 1'b0});

        foreach (vecs[i]) begin
            @(negedge clk);
            we8      = vecs[i].we;
            addr_a8  = vecs[i].addr_a;
            address8 = vecs[i].address;
            in8      = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_out_a", i), 32'(out_a8), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d_out", i), 32'(out8), 32'(vecs[i].exp_d));
            err_q.push_back(vecs[i].exp_err);
            @(posedge clk);
            #1;
            we8 = 1'b0;
            if (err_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL vec%0d_err: scoreboard empty, got %0b", i, err8);
            end else begin
                check($sformatf("vec%0d_err", i), 32'(err8), 32'(err_q.pop_front()));
            end
        end

        // 16-bit instance: zero-extended boot data and a full-width write.
        @(negedge clk);
        addr_a16 = 8'h04; address16 = 8'h04;
        #1;
        check("w16_boot_a", 32'(out_a16), 32'h0099);
        check("w16_boot_d", 32'(out16), 32'h0099);
        @(negedge clk);
        we16 = 1'b1; address16 = 8'hFF; addr_a16 = 8'hFF; in16 = 16'hBEEF;
        #1;
        check("w16_old", 32'(out16), 32'h0000);
        @(posedge clk);
        #1;
        we16 = 1'b0;
        check("w16_err", 32'(err16), 0);
        @(negedge clk);
        #1;
        check("w16_new_a", 32'(out_a16), 32'hBEEF);
        check("w16_new_d", 32'(out16), 32'hBEEF);

        // Reset mid-sweep, with err raised just before the asynchronous reset lands.
        @(negedge clk);
        nRst = 1'b0;
        #1;
        check("rst2_re", 32'(re8), 0);
        check("rst2_out_a", 32'(out_a8), 0);
        @(negedge clk);
        nRst = 1'b1;
        repeat (99) @(posedge clk);
        @(negedge clk);
        we8 = 1'b1; address8 = 8'h40;
        @(posedge clk);
        #1;
        we8 = 1'b0;
        check("mid_sweep_re", 32'(re8), 0);
        check("mid_sweep_err", 32'(err8), 1);
        nRst = 1'b0;
        #1;
        check("async_rst_err", 32'(err8), 0);
        check("async_rst_re", 32'(re8), 0);
        @(negedge clk);
        nRst = 1'b1;
        sweep(0, re_edge, err_hits, err_first, early_rd, re16_end);
        check("re2_rise_edge", 32'(re_edge), 256);
        check("re2_no_err", 32'(err_hits), 0);
        check("re2_reads_zero", 32'(early_rd), 0);
        read8("boot2_addr2", 8'h02, 8'h6C);
        read8("boot2_addr10", 8'h0A, 8'h80);
        read8("boot2_addr40", 8'h40, 8'h00);
        read8("boot2_addr10h", 8'h10, 8'h00);
        @(negedge clk);
        addr_a16 = 8'hFF; address16 = 8'h04;
        #1;
        check("boot2_w16_ff", 32'(out_a16), 32'h0000);
        check("boot2_w16_4", 32'(out16), 32'h0099);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
